// File: rtl/block_encode_dc_coeff.sv
// Serialises one DC coefficient as an MSB-first bitstream: the dct_dc_size
// VLC (luma or chroma table), then the low Size bits of the adjusted differential.
// Handshake: a bit moves on any cycle where Data_Valid_O and Ready_I are both high.

`ifndef BLOCK_DECODE_LUMA_SEL
`define BLOCK_DECODE_LUMA_SEL 1'b1
`endif

module block_encode_dc_coeff #(
    parameter int unsigned MAX_SIZE = 11
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        Start_I,
    input  logic        Luma_Chroma_Sel_I,
    input  logic [3:0]  Size_I,
    input  logic [11:0] Diff_I,
    input  logic        Ready_I,
    output logic        Data_Out_O,
    output logic        Data_Valid_O,
    output logic        Busy_O,
    output logic        Done_O,
    output logic        Error_O
);

    typedef enum logic [1:0] {StIdle, StSizeCode, StDiff, StDone} state_e;

    state_e      state_q, state_d;
    logic [9:0]  code_sr_q, code_sr_d;
    logic [10:0] diff_sr_q, diff_sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  size_q, size_d;
    logic        data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [3:0]  tbl_len;
    logic [9:0]  tbl_code;
    logic [9:0]  code_aligned;
    logic [10:0] diff_adj;
    logic [10:0] diff_aligned;
    logic        size_bad;
    logic        xfer;

    // VLC lookup for the requested size; codes are right-aligned with their length.
    always_comb begin
        tbl_len  = 4'd2;
        tbl_code = 10'd0;
        if (Luma_Chroma_Sel_I == `BLOCK_DECODE_LUMA_SEL) begin
            case (Size_I)
                4'd0:    begin tbl_len = 4'd3; tbl_code = 10'd4;   end
                4'd1:    begin tbl_len = 4'd2; tbl_code = 10'd0;   end
                4'd2:    begin tbl_len = 4'd2; tbl_code = 10'd1;   end
                4'd3:    begin tbl_len = 4'd3; tbl_code = 10'd5;   end
                4'd4:    begin tbl_len = 4'd3; tbl_code = 10'd6;   end
                4'd5:    begin tbl_len = 4'd4; tbl_code = 10'd14;  end
                4'd6:    begin tbl_len = 4'd5; tbl_code = 10'd30;  end
                4'd7:    begin tbl_len = 4'd6; tbl_code = 10'd62;  end
                4'd8:    begin tbl_len = 4'd7; tbl_code = 10'd126; end
                4'd9:    begin tbl_len = 4'd8; tbl_code = 10'd254; end
                4'd10:   begin tbl_len = 4'd9; tbl_code = 10'd510; end
                4'd11:   begin tbl_len = 4'd9; tbl_code = 10'd511; end
                default: begin tbl_len = 4'd2; tbl_code = 10'd0;   end
            endcase
        end else begin
            case (Size_I)
                4'd0:    begin tbl_len = 4'd2;  tbl_code = 10'd0;    end
                4'd1:    begin tbl_len = 4'd2;  tbl_code = 10'd1;    end
                4'd2:    begin tbl_len = 4'd2;  tbl_code = 10'd2;    end
                4'd3:    begin tbl_len = 4'd3;  tbl_code = 10'd6;    end
                4'd4:    begin tbl_len = 4'd4;  tbl_code = 10'd14;   end
                4'd5:    begin tbl_len = 4'd5;  tbl_code = 10'd30;   end
                4'd6:    begin tbl_len = 4'd6;  tbl_code = 10'd62;   end
                4'd7:    begin tbl_len = 4'd7;  tbl_code = 10'd126;  end
                4'd8:    begin tbl_len = 4'd8;  tbl_code = 10'd254;  end
                4'd9:    begin tbl_len = 4'd9;  tbl_code = 10'd510;  end
                4'd10:   begin tbl_len = 4'd10; tbl_code = 10'd1022; end
                4'd11:   begin tbl_len = 4'd10; tbl_code = 10'd1023; end
                default: begin tbl_len = 4'd2;  tbl_code = 10'd0;    end
            endcase
        end
    end

    // Operand shaping at capture: left-align the code; negative diffs use diff-1,
    // and left-aligning the low Size bits drops everything above them.
    always_comb begin
        code_aligned = tbl_code << (4'd10 - tbl_len);
        diff_adj     = Diff_I[10:0] - {10'd0, Diff_I[11]};
        diff_aligned = diff_adj << (4'd11 - Size_I);
        size_bad     = 32'(Size_I) > MAX_SIZE;
        xfer         = valid_q & Ready_I;
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        code_sr_d  = code_sr_q;
        diff_sr_d  = diff_sr_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (Start_I) begin
                    if (size_bad) begin
                        error_d = 1'b1;
                    end else begin
                        state_d    = StSizeCode;
                        code_sr_d  = code_aligned;
                        diff_sr_d  = diff_aligned;
                        cnt_d      = tbl_len;
                        size_d     = Size_I;
                        data_out_d = code_aligned[9];
                        valid_d    = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            StSizeCode: begin
                if (xfer) begin
                    if (cnt_q > 4'd1) begin
                        code_sr_d  = code_sr_q << 1;
                        cnt_d      = cnt_q - 4'd1;
                        data_out_d = code_sr_q[8];
                    end else if (size_q != 4'd0) begin
                        state_d    = StDiff;
                        cnt_d      = size_q;
                        data_out_d = diff_sr_q[10];
                    end else begin
                        state_d = StDone;
                        cnt_d   = 4'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDiff: begin
                if (xfer) begin
                    if (cnt_q > 4'd1) begin
                        diff_sr_d  = diff_sr_q << 1;
                        cnt_d      = cnt_q - 4'd1;
                        data_out_d = diff_sr_q[9];
                    end else begin
                        state_d = StDone;
                        cnt_d   = 4'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            code_sr_q  <= 10'd0;
            diff_sr_q  <= 11'd0;
            cnt_q      <= 4'd0;
            size_q     <= 4'd0;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_sr_q  <= code_sr_d;
            diff_sr_q  <= diff_sr_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign Data_Out_O   = data_out_q;
    assign Data_Valid_O = valid_q;
    assign Busy_O       = busy_q;
    assign Done_O       = done_q;
    assign Error_O      = error_q;

endmodule

// File: doc/block_encode_dc_coeff.md
BLOCK_ENCODE_DC_COEFF -- requirements
Module: block_encode_dc_coeff

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 11, meaning the largest legal dct_dc_size.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start_I, input, 1 bit: request to encode one DC coefficient.
REQ-005 SHALL have port Luma_Chroma_Sel_I, input, 1 bit: selects Table B.12 when equal to `BLOCK_DECODE_LUMA_SEL, otherwise Table B.13.
REQ-006 SHALL have port Size_I, input, 4 bits: dct_dc_size, 0..MAX_SIZE.
REQ-007 SHALL have port Diff_I, input, 12 bits: signed two's-complement DC differential.
REQ-008 SHALL have port Ready_I, input, 1 bit: downstream accepts the presented bit this cycle.
REQ-009 SHALL have port Data_Out_O, output, 1 bit: current serial bitstream bit, MSB first.
REQ-010 SHALL have port Data_Valid_O, output, 1 bit: Data_Out_O is valid.
REQ-011 SHALL have port Busy_O, output, 1 bit: encode in progress.
REQ-012 SHALL have port Done_O, output, 1 bit: one-cycle pulse after the last bit is accepted.
REQ-013 SHALL have port Error_O, output, 1 bit: one-cycle pulse on Start_I with Size_I > MAX_SIZE.

Function
REQ-014 SHALL implement FSM states IDLE, SIZE_CODE, DIFF, DONE; all outputs registered.
REQ-015 In IDLE, Start_I SHALL capture Luma_Chroma_Sel_I, Size_I, Diff_I; the next state is SIZE_CODE, with Busy_O and Data_Valid_O high on the next cycle (1-cycle latency).
REQ-016 Start_I while Busy_O is high SHALL be ignored, with no effect on the captured operands.
REQ-017 Luma codes (size 0..11) SHALL be: 100, 00, 01, 101, 110, 1110, 11110, 111110, 1111110, 11111110, 111111110, 111111111.
REQ-018 Chroma codes (size 0..11) SHALL be: 00, 01, 10, 110, 1110, 11110, 111110, 1111110, 11111110, 111111110, 1111111110, 1111111111.
REQ-019 Code length SHALL be held in a 4-bit down-counter; the code SHALL be left-aligned in a 10-bit shift register.
REQ-020 A bit transfer SHALL occur only on a cycle with Data_Valid_O and Ready_I both high; otherwise Data_Out_O SHALL hold its value.
REQ-021 After the last code bit transfers, the FSM SHALL go to DIFF if size > 0, else to DONE.
REQ-022 DIFF SHALL emit the low Size bits of (Diff_I >= 0 ? Diff_I : Diff_I - 1), MSB first, with 12-bit wrap arithmetic.
REQ-023 After the last DIFF bit transfers, the FSM SHALL enter DONE with Data_Valid_O low, pulse Done_O for one cycle, and return to IDLE with Busy_O low.
REQ-024 A new Start_I SHALL be accepted on the cycle after DONE (back-to-back gap of exactly 1 idle cycle).
REQ-025 Size_I > MAX_SIZE on Start_I SHALL pulse Error_O the next cycle, leave the FSM in IDLE, and emit no bits.
REQ-026 Consistency between Diff_I and Size_I is the caller's responsibility and SHALL NOT be checked.

Reset
REQ-027 On resetn low, the FSM SHALL enter IDLE immediately; Data_Out_O, Data_Valid_O, Busy_O, Done_O, Error_O SHALL be 0; counters and shift registers SHALL be cleared.
REQ-028 Reset mid-encode SHALL abort the encode with no Done_O pulse; the first Start_I after release SHALL encode normally.

Verification
REQ-029 Luma, Size 0, Ready_I=1 -> bits 1,0,0 on 3 consecutive cycles, then Done_O pulse; total Busy_O of 4 cycles.
REQ-030 Luma, Size 3, Diff -5, Ready_I=1 -> bits 1,0,1,0,1,0, then Done_O.
REQ-031 Chroma, Size 11, Diff 1024 -> ten 1s, then 1 followed by ten 0s (21 bits), then Done_O.
REQ-032 Chroma, Size 2, Diff 3, with Ready_I low for 3 cycles after the first bit -> Data_Out_O holds 1 while stalled; the full sequence is 1,0,1,1.
REQ-033 Size 12 -> Error_O pulses once, Data_Valid_O and Busy_O stay 0; a Start_I during busy is ignored and the output is unchanged.
REQ-034 resetn asserted after 2 bits of a Size 5 encode -> all outputs 0 at once, no Done_O; a subsequent Luma Size 1, Diff 1 -> bits 0,0,1.
